// File: rtl/alu_issue_decode.sv
// RV32I decode/issue stage: decodes one instruction per cycle into ALU operands and function
// selects, forwards the ALU result into a dependent follower, and holds it until execute takes it.
module alu_issue_decode #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [XLEN-1:0]  if_instr,
  input  logic [XLEN-1:0]  if_pc,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  alu_in1,
  output logic [XLEN-1:0]  alu_in2,
  output logic [2:0]       alu_func3,
  output logic [6:0]       alu_func7,
  output logic [4:0]       rd,
  output logic             wb_en,
  output logic             illegal,
  output logic [CNT_W-1:0] issued_count
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [2:0] F3_ADD     = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SR      = 3'b101;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  alu_in1_q, alu_in1_d;
  logic [XLEN-1:0]  alu_in2_q, alu_in2_d;
  logic [2:0]       alu_func3_q, alu_func3_d;
  logic [6:0]       alu_func7_q, alu_func7_d;
  logic [4:0]       rd_q, rd_d;
  logic             wb_en_q, wb_en_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] issued_count_q, issued_count_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;
  logic            accept;
  logic            consume;
  logic            fwd_rs1;
  logic            fwd_rs2;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;

  logic [XLEN-1:0] dec_in1;
  logic [XLEN-1:0] dec_in2;
  logic [2:0]      dec_func3;
  logic [6:0]      dec_func7;
  logic            dec_illegal;
  logic [4:0]      dec_rd;
  logic            dec_wb_en;

  assign opcode   = if_instr[6:0];
  assign funct3   = if_instr[14:12];
  assign funct7   = if_instr[31:25];
  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];
  assign imm_i    = XLEN'($signed(if_instr[31:20]));
  assign imm_u    = XLEN'($signed({if_instr[31:12], 12'b0}));
  assign shamt    = XLEN'(if_instr[24:20]);

  assign if_ready = !out_valid_q || out_ready;
  assign accept   = if_valid && if_ready && !flush;
  assign consume  = out_valid_q && out_ready;

  // The held op writes the regfile at the same edge its follower is accepted, so the
  // follower must take the ALU result instead of the stale regfile read.
  always_comb begin
    fwd_rs1 = accept && consume && wb_en_q && (rd_q != 5'd0) && (rd_q == rs1_addr);
    fwd_rs2 = accept && consume && wb_en_q && (rd_q != 5'd0) && (rd_q == rs2_addr);
    src1    = fwd_rs1 ? alu_result : rs1_data;
    src2    = fwd_rs2 ? alu_result : rs2_data;
  end

  always_comb begin
    dec_in1     = '0;
    dec_in2     = '0;
    dec_func3   = F3_ADD;
    dec_func7   = F7_BASE;
    dec_illegal = 1'b0;
    dec_rd      = if_instr[11:7];
    case (opcode)
      OPC_OP: begin
        dec_in1     = src1;
        dec_in2     = src2;
        dec_func3   = funct3;
        dec_func7   = funct7;
        dec_illegal = !((funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR))));
      end
      OPC_OP_IMM: begin
        dec_in1   = src1;
        dec_func3 = funct3;
        if ((funct3 == F3_SLL) || (funct3 == F3_SR)) begin
          dec_in2     = shamt;
          dec_func7   = ((funct3 == F3_SR) && if_instr[30]) ? F7_ALT : F7_BASE;
          dec_illegal = !((funct7 == F7_BASE) || ((funct3 == F3_SR) && (funct7 == F7_ALT)));
        end else begin
          dec_in2 = imm_i;
        end
      end
      OPC_LUI: begin
        dec_in2 = imm_u;
      end
      OPC_AUIPC: begin
        dec_in1 = if_pc;
        dec_in2 = imm_u;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
    // Illegal ops carry no operands; execute only needs the illegal flag to trap.
    if (dec_illegal) begin
      dec_in1   = '0;
      dec_in2   = '0;
      dec_func3 = F3_ADD;
      dec_func7 = F7_BASE;
    end
    dec_wb_en = !dec_illegal && (dec_rd != 5'd0);
  end

  always_comb begin
    alu_in1_d      = alu_in1_q;
    alu_in2_d      = alu_in2_q;
    alu_func3_d    = alu_func3_q;
    alu_func7_d    = alu_func7_q;
    rd_d           = rd_q;
    wb_en_d        = wb_en_q;
    illegal_d      = illegal_q;
    out_valid_d    = out_valid_q;
    issued_count_d = issued_count_q + (consume ? CNT_W'(1) : CNT_W'(0));
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      alu_in1_d   = dec_in1;
      alu_in2_d   = dec_in2;
      alu_func3_d = dec_func3;
      alu_func7_d = dec_func7;
      rd_d        = dec_rd;
      wb_en_d     = dec_wb_en;
      illegal_d   = dec_illegal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      alu_in1_q      <= '0;
      alu_in2_q      <= '0;
      alu_func3_q    <= '0;
      alu_func7_q    <= '0;
      rd_q           <= '0;
      wb_en_q        <= 1'b0;
      illegal_q      <= 1'b0;
      issued_count_q <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      alu_in1_q      <= alu_in1_d;
      alu_in2_q      <= alu_in2_d;
      alu_func3_q    <= alu_func3_d;
      alu_func7_q    <= alu_func7_d;
      rd_q           <= rd_d;
      wb_en_q        <= wb_en_d;
      illegal_q      <= illegal_d;
      issued_count_q <= issued_count_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign alu_in1      = alu_in1_q;
  assign alu_in2      = alu_in2_q;
  assign alu_func3    = alu_func3_q;
  assign alu_func7    = alu_func7_q;
  assign rd           = rd_q;
  assign wb_en        = wb_en_q;
  assign illegal      = illegal_q;
  assign issued_count = issued_count_q;

endmodule

// File: tb/tb_alu_issue_decode.sv
// Randomized bench for alu_issue_decode against an architectural model: a register file that
// is updated when ops are consumed, so correct forwarding shows up as correct operand values.
module tb_alu_issue_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] alu_result;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [2:0]  alu_func3;
  logic [6:0]  alu_func7;
  logic [4:0]  rd;
  logic        wb_en;
  logic        illegal;
  logic [31:0] issued_count;

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic        wb;
    logic        ill;
  } op_t;

  logic [31:0] regs [32];
  op_t         m_op;
  logic        m_valid;
  logic [31:0] m_count;
  int          checks = 0;
  int          passes = 0;

  alu_issue_decode #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .alu_result(alu_result), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_func3(alu_func3),
    .alu_func7(alu_func7), .rd(rd), .wb_en(wb_en), .illegal(illegal),
    .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // What the instruction means architecturally, given its true source register values.
  function automatic op_t refDecode(input logic [31:0] ins, input logic [31:0] pc,
                                    input logic [31:0] a, input logic [31:0] b);
    op_t o;
    logic [2:0] f3;
    logic [6:0] f7;
    o  = '0;
    f3 = ins[14:12];
    f7 = ins[31:25];
    o.rd = ins[11:7];
    case (ins[6:0])
      7'h33: begin
        o.in1 = a; o.in2 = b; o.f3 = f3; o.f7 = f7;
        o.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      7'h13: begin
        o.in1 = a; o.f3 = f3;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          o.in2 = {27'd0, ins[24:20]};
          o.f7  = (f3 == 3'd5 && ins[30]) ? 7'h20 : 7'h00;
          o.ill = !(f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20));
        end else begin
          o.in2 = {{20{ins[31]}}, ins[31:20]};
        end
      end
      7'h37: o.in2 = {ins[31:12], 12'd0};
      7'h17: begin o.in1 = pc; o.in2 = {ins[31:12], 12'd0}; end
      default: o.ill = 1'b1;
    endcase
    if (o.ill) begin o.in1 = 0; o.in2 = 0; o.f3 = 0; o.f7 = 0; end
    o.wb = !o.ill && (o.rd != 5'd0);
    return o;
  endfunction

  function automatic logic [31:0] refAlu(input op_t o);
    case (o.f3)
      3'd0: return o.f7[5] ? o.in1 - o.in2 : o.in1 + o.in2;
      3'd1: return o.in1 << o.in2[4:0];
      3'd2: return ($signed(o.in1) < $signed(o.in2)) ? 32'd1 : 32'd0;
      3'd3: return (o.in1 < o.in2) ? 32'd1 : 32'd0;
      3'd4: return o.in1 ^ o.in2;
      3'd5: return o.f7[5] ? $unsigned($signed(o.in1) >>> o.in2[4:0]) : o.in1 >> o.in2[4:0];
      3'd6: return o.in1 | o.in2;
      default: return o.in1 & o.in2;
    endcase
  endfunction

  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] ins,
                               input logic [31:0] pc, input logic ordy, input logic fl);
    logic cons;
    logic acc;
    rst = r; if_valid = v; if_instr = ins; if_pc = pc; out_ready = ordy; flush = fl;
    rs1_data   = regs[ins[19:15]];
    rs2_data   = regs[ins[24:20]];
    alu_result = refAlu(m_op);
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0; m_op = '0; m_count = 0;
    end else begin
      cons = m_valid && ordy;
      acc  = v && (!m_valid || ordy) && !fl;
      if (cons && m_op.wb) regs[m_op.rd] = alu_result;
      if (cons) m_count = m_count + 1;
      if (acc) begin
        m_op    = refDecode(ins, pc, regs[ins[19:15]], regs[ins[24:20]]);
        m_valid = 1'b1;
      end else if (fl || ordy) begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    checkOutput("if_ready", {31'd0, if_ready}, {31'd0, !m_valid || out_ready});
    checkOutput("issued_count", issued_count, m_count);
    checkOutput("alu_in1", alu_in1, m_op.in1);
    checkOutput("alu_in2", alu_in2, m_op.in2);
    checkOutput("alu_func3", {29'd0, alu_func3}, {29'd0, m_op.f3});
    checkOutput("alu_func7", {25'd0, alu_func7}, {25'd0, m_op.f7});
    checkOutput("rd", {27'd0, rd}, {27'd0, m_op.rd});
    checkOutput("wb_en", {31'd0, wb_en}, {31'd0, m_op.wb});
    checkOutput("illegal", {31'd0, illegal}, {31'd0, m_op.ill});
    checkOutput("rs1_addr", {27'd0, rs1_addr}, {27'd0, ins[19:15]});
    checkOutput("rs2_addr", {27'd0, rs2_addr}, {27'd0, ins[24:20]});
  endtask

  function automatic logic [31:0] randInstr();
    logic [4:0] r_d, r_s1, r_s2;
    logic [2:0] f3;
    logic [6:0] top;
    int         sel;
    r_d  = 5'($urandom_range(0, 7));
    r_s1 = 5'($urandom_range(0, 7));
    r_s2 = 5'($urandom_range(0, 7));
    f3   = 3'($urandom_range(0, 7));
    sel  = $urandom_range(0, 9);
    case ($urandom_range(0, 4))
      0, 1:    top = 7'h00;
      2, 3:    top = 7'h20;
      default: top = 7'($urandom);
    endcase
    if (sel <= 3) return {top, r_s2, r_s1, f3, r_d, 7'h33};
    if (sel <= 6) begin
      if (f3 == 3'd1 || f3 == 3'd5) return {top, r_s2, r_s1, f3, r_d, 7'h13};
      return {12'($urandom), r_s1, f3, r_d, 7'h13};
    end
    if (sel == 7) return {20'($urandom), r_d, 7'h37};
    if (sel == 8) return {20'($urandom), r_d, 7'h17};
    return {25'($urandom), 7'($urandom)};
  endfunction

  initial begin
    m_valid = 1'b0; m_op = '0; m_count = 0;
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
    applyStimulus(1, 0, 32'h0, 32'h0, 1, 0);
    applyStimulus(1, 0, 32'h0, 32'h0, 1, 0);

    regs[1] = 32'd5; regs[2] = 32'd3;
    applyStimulus(0, 1, 32'h40208033, 32'h100, 1, 0);
    checkOutput("sub_func7", {25'd0, alu_func7}, 32'h20);
    checkOutput("sub_in1", alu_in1, 32'd5);
    checkOutput("sub_wb_en", {31'd0, wb_en}, 32'd0);

    applyStimulus(0, 1, 32'h40315093, 32'h104, 1, 0);
    checkOutput("srai_func3", {29'd0, alu_func3}, 32'd5);
    checkOutput("srai_func7", {25'd0, alu_func7}, 32'h20);
    checkOutput("srai_in2", alu_in2, 32'd3);
    applyStimulus(0, 1, 32'h00310093, 32'h108, 1, 0);
    checkOutput("addi_func7", {25'd0, alu_func7}, 32'h00);
    checkOutput("addi_in2", alu_in2, 32'd3);

    applyStimulus(0, 0, 32'h0, 32'h0, 1, 0);
    regs[1] = 32'd0;
    applyStimulus(0, 1, 32'h00700093, 32'h10c, 1, 0);
    applyStimulus(0, 1, 32'h001081B3, 32'h110, 1, 0);
    checkOutput("fwd_in1", alu_in1, 32'd7);
    checkOutput("fwd_in2", alu_in2, 32'd7);

    for (int i = 0; i < 3; i++) applyStimulus(0, 1, randInstr(), 32'h200 + 4 * i, 0, 0);
    applyStimulus(0, 1, randInstr(), 32'h210, 1, 0);
    applyStimulus(0, 1, randInstr(), 32'h214, 1, 0);

    applyStimulus(0, 1, randInstr(), 32'h218, 0, 1);
    applyStimulus(0, 1, 32'h0000007F, 32'h21c, 0, 0);
    checkOutput("illegal_flag", {31'd0, illegal}, 32'd1);
    checkOutput("illegal_wb", {31'd0, wb_en}, 32'd0);

    applyStimulus(0, 1, randInstr(), 32'h220, 0, 0);
    applyStimulus(1, 1, randInstr(), 32'h224, 0, 0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_count", issued_count, 32'd0);

    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), randInstr(),
                    $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0));
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
